if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words (output register plus one skid entry) and presents if_pc/if_inst/if_valid to IF/ID.
- Honours stall from the hazard unit and branch/jump redirects resolved in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
ADDR_W, 32, PC/instruction address width
INST_W, 32, instruction width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_in  in  1  downstream cannot accept; hold if_* stable
br_taken  in  1  single-cycle redirect pulse from ID
br_target  in  ADDR_W  redirect PC, valid with br_taken
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, word aligned
imem_ack  in  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  in  INST_W  fetched word
if_pc  out  ADDR_W  PC of presented instruction
if_inst  out  INST_W  presented instruction
if_valid  out  1  if_pc/if_inst valid

Behaviour:
- All outputs registered. Reset (async) values: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=0, if_pc=0, if_inst=0 (NOP), if_valid=0, skid empty, redirect register=0.
- First imem_req rises the first clock after rst deasserts.
- Handshake: once raised, imem_req and imem_addr stay stable until a cycle with imem_ack=1. Data is captured in the ack cycle. Memory latency is arbitrary (>=0 wait cycles). imem_ack while imem_req=0 is ignored.
- Consume: if_valid=1 and stall_in=0 at a clock edge. While stall_in=1, if_pc/if_inst/if_valid hold stable.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On ack:
    - If the output slot is free or being consumed, load if_* with {pc, rdata}, set if_valid=1, pc<=pc+4, stay FETCH.
    - Otherwise write the skid entry, pc<=pc+4, go HOLD.
    - Back-to-back: with zero-wait memory and stall_in=0, throughput is one instruction per cycle.
  - HOLD: imem_req=0. When the output is consumed, the skid entry moves to the output and the FSM goes to FETCH.
  - DROP: entered on br_taken while a request is outstanding without ack. imem_req stays high with the old address; the ack data is discarded; pc<=saved target; go FETCH.
- Redirect (br_taken=1), which takes priority over stall_in:
  - if_valid<=0 and skid cleared on the next edge.
  - pc<=br_target.
  - Outstanding request without ack -> DROP, target saved.
  - Ack in the same cycle as br_taken -> data discarded; next state FETCH at br_target.
  - br_taken in HOLD -> FETCH at br_target.
  - br_taken during DROP overwrites the saved target.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] of br_target are forced to 0.
- Latency: if_valid rises 1 cycle after the ack cycle. A redirect produces the first target instruction at least 2 cycles after br_taken.

Optional Feature:
- Macro: IF_BR_DELAY_SLOT_EN.
- Defined: MIPS delay slot. On br_taken, the output register entry (the instruction after the branch) is preserved and if_valid is not cleared. Skid entry and in-flight fetch are still dropped.
- Defined, interface rule: ID asserts br_taken only while if_valid=1.
- Undefined: full squash as described in Behaviour.

Test Plan:
- Reset then zero-wait memory returning addr-as-data, stall_in=0 -> imem_addr 0,4,8,...; if_pc/if_inst 0,4,8 on consecutive cycles; if_valid=1 from cycle 2.
- 3-wait-cycle memory -> imem_req/imem_addr stable for 4 cycles per fetch; one if_valid update per ack.
- stall_in=1 for 5 cycles while pc=8 output is held and the next ack (pc=12) arrives -> skid holds 12, imem_req=0; on stall release if_pc goes 8 then 12, then fetch resumes at 16.
- br_taken with br_target=0x100 while a request to 0x20 is outstanding, ack 2 cycles later -> 0x20 data never appears; next imem_addr=0x100; if_valid=0 in between.
- br_taken coincident with ack and stall_in=1 -> output and skid flushed, fetch at target; br_target=0x103 fetches 0x100.
- With IF_BR_DELAY_SLOT_EN defined, br_taken while if_pc=0x44 is valid -> 0x44 still delivered, next if_pc=br_target.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches over imem req/ack, presents words to IF/ID via output reg + 1 skid entry.
// if_valid rises 1 cycle after ack; stall_in holds if_*; IF_BR_DELAY_SLOT_EN keeps the output entry on a redirect.
module if_fetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              if_valid
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   entry_t            out_q, out_d;
   logic              out_vld_q, out_vld_d;
   entry_t            skid_q, skid_d;
   logic              skid_vld_q, skid_vld_d;
   logic [ADDR_W-1:0] redir_q, redir_d;

   logic              consume;
   logic              ack;
   logic [ADDR_W-1:0] tgt;

   assign consume = out_vld_q & ~stall_in;
   assign ack     = req_q & imem_ack;
   assign tgt     = br_target & ALIGN_MASK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         redir_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         redir_q    <= redir_d;
      end
   end

   // pc_q always equals the address of the request in flight (or about to be raised) while in FETCH
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      redir_d    = redir_q;

      if (consume) begin
         out_vld_d = 1'b0;
      end

      if (br_taken) begin
         skid_vld_d = 1'b0;
`ifndef IF_BR_DELAY_SLOT_EN
         out_vld_d  = 1'b0;
`endif
         pc_d       = tgt;
         redir_d    = tgt;
         // An unacked request cannot be withdrawn, so ride it out in DROP
         if (req_q && !imem_ack) begin
            state_d = DROP;
         end else begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = tgt;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (!req_q) begin
                  req_d  = 1'b1;
                  addr_d = pc_q;
               end else if (ack) begin
                  pc_d = pc_q + PC_STEP;
                  if (!out_vld_q || consume) begin
                     out_d     = '{pc: addr_q, inst: imem_rdata};
                     out_vld_d = 1'b1;
                     addr_d    = pc_q + PC_STEP;
                  end else begin
                     skid_d     = '{pc: addr_q, inst: imem_rdata};
                     skid_vld_d = 1'b1;
                     req_d      = 1'b0;
                     state_d    = HOLD;
                  end
               end
            end
            HOLD: begin
               if (consume) begin
                  out_d      = skid_q;
                  out_vld_d  = skid_vld_q;
                  skid_vld_d = 1'b0;
                  req_d      = 1'b1;
                  addr_d     = pc_q;
                  state_d    = FETCH;
               end
            end
            DROP: begin
               if (ack) begin
                  pc_d    = redir_q;
                  req_d   = 1'b1;
                  addr_d  = redir_q;
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = FETCH;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_pc     = out_q.pc;
   assign if_inst   = out_q.inst;
   assign if_valid  = out_vld_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, wait states, stall/skid, redirects (incl. DROP) and PC wrap.
module tb_if_fetch;

   localparam logic [31:0] KEY = 32'h5A00_0000;
`ifdef IF_BR_DELAY_SLOT_EN
   localparam logic DS = 1'b1;
`else
   localparam logic DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        br_taken;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;

   int n_chk  = 0;
   int n_fail = 0;
   int wait_n = 0;
   int wcnt   = 0;

   if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall_in   (stall_in),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_pc      (if_pc),
      .if_inst    (if_inst),
      .if_valid   (if_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_fetch(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
      if (req) chk({tag, ".addr"}, imem_addr, addr);
   endtask

   task automatic exp_out(input string tag, input logic vld, input logic [31:0] pc);
      chk({tag, ".vld"}, {31'b0, if_valid}, {31'b0, vld});
      if (vld) begin
         chk({tag, ".pc"}, if_pc, pc);
         chk({tag, ".inst"}, if_inst, pc ^ KEY);
      end
   endtask

   // One clock: drive inputs and the memory response, step the edge, sample #1 later
   task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic stray);
      logic req_now;
      stall_in  = s;
      br_taken  = b;
      br_target = t;
      req_now   = imem_req;
      if (stray) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
      end else if (req_now && wcnt >= wait_n) begin
         imem_ack   = 1'b1;
         imem_rdata = imem_addr ^ KEY;
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hBAD0_BAD0;
      end
      @(posedge clk);
      if (!req_now || imem_ack) wcnt = 0;
      else wcnt++;
      #1;
   endtask

   initial begin
      rst = 1'b1; stall_in = 1'b0; br_taken = 1'b0; br_target = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst.req",  {31'b0, imem_req}, 32'd0);
      chk("rst.addr", imem_addr, 32'd0);
      chk("rst.vld",  {31'b0, if_valid}, 32'd0);
      chk("rst.pc",   if_pc, 32'd0);
      chk("rst.inst", if_inst, 32'd0);
      rst = 1'b0;

      // zero-wait streaming
      cyc(0, 0, 0, 0); exp_fetch("c1", 1, 32'h0); exp_out("c1", 0, 0);
      cyc(0, 0, 0, 0); exp_fetch("c2", 1, 32'h4); exp_out("c2", 1, 32'h0);
      cyc(0, 0, 0, 0); exp_fetch("c3", 1, 32'h8); exp_out("c3", 1, 32'h4);
      cyc(0, 0, 0, 0); exp_fetch("c4", 1, 32'hC); exp_out("c4", 1, 32'h8);

      // stall: ack for 0xC lands in skid, request drops; stray ack ignored
      cyc(1, 0, 0, 0); exp_fetch("stall0", 0, 0); exp_out("stall0", 1, 32'h8);
      cyc(1, 0, 0, 1); exp_fetch("stray", 0, 0); exp_out("stray", 1, 32'h8);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0); exp_fetch("stallN", 0, 0); exp_out("stallN", 1, 32'h8);
      end
      cyc(0, 0, 0, 0); exp_fetch("rel0", 1, 32'h10); exp_out("rel0", 1, 32'hC);
      cyc(0, 0, 0, 0); exp_fetch("rel1", 1, 32'h14); exp_out("rel1", 1, 32'h10);

      // three wait states
      wait_n = 3;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0); exp_fetch("wait", 1, 32'h14); exp_out("wait", 0, 0);
      end
      cyc(0, 0, 0, 0); exp_fetch("wack", 1, 32'h18); exp_out("wack", 1, 32'h14);
      cyc(0, 0, 0, 0); exp_fetch("wpost", 1, 32'h18); exp_out("wpost", 0, 0);
      wait_n = 0;
      cyc(0, 0, 0, 0); exp_out("s18", 1, 32'h18);
      cyc(0, 0, 0, 0); exp_fetch("s1c", 1, 32'h20); exp_out("s1c", 1, 32'h1C);

      // redirect with 0x20 outstanding: DROP then fetch 0x100
      wait_n = 3;
      cyc(0, 0, 0, 0); exp_fetch("d0", 1, 32'h20); exp_out("d0", 0, 0);
      cyc(0, 1, 32'h100, 0); exp_fetch("d1", 1, 32'h20); exp_out("d1", 0, 0);
      cyc(0, 0, 0, 0); exp_fetch("d2", 1, 32'h20); exp_out("d2", 0, 0);
      cyc(0, 0, 0, 0); exp_fetch("d3", 1, 32'h100); exp_out("d3", 0, 0);
      wait_n = 0;
      cyc(0, 0, 0, 0); exp_fetch("d4", 1, 32'h104); exp_out("d4", 1, 32'h100);

      // redirect coincident with ack under stall, unaligned target
      cyc(1, 1, 32'h303, 0); exp_fetch("ba0", 1, 32'h300); exp_out("ba0", DS, 32'h100);
      cyc(0, 0, 0, 0); exp_fetch("ba1", 1, 32'h304); exp_out("ba1", 1, 32'h300);

      // redirect from HOLD drops skid entry 0x304
      cyc(1, 0, 0, 0); exp_fetch("h0", 0, 0); exp_out("h0", 1, 32'h300);
      cyc(1, 1, 32'h40, 0); exp_fetch("h1", 1, 32'h40); exp_out("h1", DS, 32'h300);
      cyc(0, 0, 0, 0); exp_fetch("h2", 1, 32'h44); exp_out("h2", 1, 32'h40);
      cyc(0, 0, 0, 0); exp_fetch("h3", 1, 32'h48); exp_out("h3", 1, 32'h44);

      // redirect to top of address space while 0x44 presented; PC wraps
      cyc(1, 1, 32'hFFFF_FFFE, 0); exp_fetch("w0", 1, 32'hFFFF_FFFC); exp_out("w0", DS, 32'h44);
      cyc(0, 0, 0, 0); exp_fetch("w1", 1, 32'h0); exp_out("w1", 1, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0); exp_fetch("w2", 1, 32'h4); exp_out("w2", 1, 32'h0);

      // second redirect while in DROP overwrites the saved target
      wait_n = 3;
      cyc(1, 0, 0, 0); exp_fetch("o0", 1, 32'h4); exp_out("o0", 1, 32'h0);
      cyc(1, 1, 32'h500, 0); exp_fetch("o1", 1, 32'h4); exp_out("o1", DS, 32'h0);
      cyc(1, 1, 32'h600, 0); exp_fetch("o2", 1, 32'h4); exp_out("o2", DS, 32'h0);
      cyc(0, 0, 0, 0); exp_fetch("o3", 1, 32'h600); exp_out("o3", 0, 0);
      wait_n = 0;
      cyc(0, 0, 0, 0); exp_fetch("o4", 1, 32'h604); exp_out("o4", 1, 32'h600);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
